// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline write-back (P) has priority over a
// FIFO-buffered long-latency stream (L), with a starvation guard and WAW kill.
module wb_port_arbiter #(
  parameter int DATA_SIZE  = 32,
  parameter int NUM_REGS   = 32,
  parameter int FIFO_DEPTH = 2,
  parameter int MAX_WAIT   = 4,
  localparam int AW = $clog2(NUM_REGS),
  localparam int CW = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                 i_aclk,
  input  logic                 i_reset,
  input  logic                 i_p_valid,
  input  logic [AW-1:0]        i_p_addr,
  input  logic [DATA_SIZE-1:0] i_p_data,
  output logic                 o_p_stall,
  input  logic                 i_l_valid,
  output logic                 o_l_ready,
  input  logic [AW-1:0]        i_l_addr,
  input  logic [DATA_SIZE-1:0] i_l_data,
  output logic                 o_wb,
  output logic [AW-1:0]        o_wb_addr,
  output logic [DATA_SIZE-1:0] o_wb_data,
  output logic [CW-1:0]        o_l_count
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int WW = $clog2(MAX_WAIT + 1);

  logic [AW-1:0]        r_addr [FIFO_DEPTH];
  logic [DATA_SIZE-1:0] r_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] r_kill;
  logic [PW-1:0]        r_head;
  logic [PW-1:0]        r_tail;
  logic [CW-1:0]        r_count;
  logic [WW-1:0]        r_wait;
  logic                 r_wb;
  logic [AW-1:0]        r_wb_addr;
  logic [DATA_SIZE-1:0] r_wb_data;

  logic                 w_ready;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_live_head;
  logic                 w_starve;
  logic                 w_grant_p;
  logic                 w_grant_l;
  logic                 w_kill_en;
  logic [AW-1:0]        w_head_addr;
  logic [DATA_SIZE-1:0] w_head_data;
  logic [CW-1:0]        w_next_count;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(FIFO_DEPTH - 1)) return '0;
    else return p + PW'(1);
  endfunction

  assign w_head_addr = r_addr[r_head];
  assign w_head_data = r_data[r_head];

  // Ready ignores a same-cycle pop so there is no ready<-grant<-input path.
  assign w_ready     = !i_reset && (r_count < CW'(FIFO_DEPTH));
  assign w_push      = i_l_valid && w_ready;
  assign w_live_head = (r_count != '0) && !r_kill[r_head];
  assign w_starve    = w_live_head && (r_wait == WW'(MAX_WAIT));

  assign w_grant_l = w_starve || (!i_p_valid && w_live_head);
  assign w_grant_p = !w_starve && i_p_valid;
  // A killed head leaves without touching the port, even alongside a P grant.
  assign w_pop     = (r_count != '0) && (r_kill[r_head] || w_grant_l);
  assign w_kill_en = w_grant_p && (i_p_addr != '0);

  // NOTE: combinational blocks assign a default first so no path infers a latch.
  always_comb begin
    w_next_count = r_count;
    case ({w_push, w_pop})
      2'b10:   w_next_count = r_count + CW'(1);
      2'b01:   w_next_count = r_count - CW'(1);
      default: w_next_count = r_count;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge i_aclk) begin
    if (i_reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= ptr_inc(r_tail);
      if (w_pop)  r_head <= ptr_inc(r_head);
      r_count <= w_next_count;
    end
  end

  // A younger P write supersedes every queued L write to the same register,
  // including the one being pushed this cycle.
  always_ff @(posedge i_aclk) begin
    if (i_reset) begin
      r_kill <= '0;
    end else begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        if (w_kill_en && (r_addr[i] == i_p_addr)) r_kill[i] <= 1'b1;
      end
      if (w_push) r_kill[r_tail] <= w_kill_en && (i_l_addr == i_p_addr);
    end
  end

  // NOTE: payload storage is not reset; occupancy and kill bits gate every use.
  always_ff @(posedge i_aclk) begin
    if (w_push) begin
      r_addr[r_tail] <= i_l_addr;
      r_data[r_tail] <= i_l_data;
    end
  end

  always_ff @(posedge i_aclk) begin
    if (i_reset) begin
      r_wait <= '0;
    end else if (!w_live_head || w_grant_l) begin
      r_wait <= '0;
    end else if (r_wait != WW'(MAX_WAIT)) begin
      r_wait <= r_wait + WW'(1);
    end
  end

  always_ff @(posedge i_aclk) begin
    if (i_reset) begin
      r_wb      <= 1'b0;
      r_wb_addr <= '0;
      r_wb_data <= '0;
    end else begin
      r_wb <= (w_grant_p && (i_p_addr != '0)) ||
              (w_grant_l && (w_head_addr != '0));
      if (w_grant_p) begin
        r_wb_addr <= i_p_addr;
        r_wb_data <= i_p_data;
      end else if (w_grant_l) begin
        r_wb_addr <= w_head_addr;
        r_wb_data <= w_head_data;
      end
    end
  end

  assign o_p_stall = w_starve;
  assign o_l_ready = w_ready;
  assign o_wb      = r_wb;
  assign o_wb_addr = r_wb_addr;
  assign o_wb_data = r_wb_data;
  assign o_l_count = r_count;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: hand-computed expectations, outputs
// sampled 1 time unit after each rising edge.
module tb_wb_port_arbiter;

  localparam int DATA_SIZE  = 32;
  localparam int NUM_REGS   = 32;
  localparam int FIFO_DEPTH = 2;
  localparam int MAX_WAIT   = 4;
  localparam int AW = $clog2(NUM_REGS);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic                 clk = 1'b0;
  logic                 i_reset;
  logic                 i_p_valid;
  logic [AW-1:0]        i_p_addr;
  logic [DATA_SIZE-1:0] i_p_data;
  logic                 o_p_stall;
  logic                 i_l_valid;
  logic                 o_l_ready;
  logic [AW-1:0]        i_l_addr;
  logic [DATA_SIZE-1:0] i_l_data;
  logic                 o_wb;
  logic [AW-1:0]        o_wb_addr;
  logic [DATA_SIZE-1:0] o_wb_data;
  logic [CW-1:0]        o_l_count;

  int n_checks = 0;
  int n_pass   = 0;

  wb_port_arbiter #(
    .DATA_SIZE(DATA_SIZE), .NUM_REGS(NUM_REGS),
    .FIFO_DEPTH(FIFO_DEPTH), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .i_aclk(clk), .i_reset(i_reset),
    .i_p_valid(i_p_valid), .i_p_addr(i_p_addr), .i_p_data(i_p_data),
    .o_p_stall(o_p_stall),
    .i_l_valid(i_l_valid), .o_l_ready(o_l_ready),
    .i_l_addr(i_l_addr), .i_l_data(i_l_data),
    .o_wb(o_wb), .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data),
    .o_l_count(o_l_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_p(input logic v, input logic [AW-1:0] a, input logic [DATA_SIZE-1:0] d);
    i_p_valid = v; i_p_addr = a; i_p_data = d;
  endtask

  task automatic set_l(input logic v, input logic [AW-1:0] a, input logic [DATA_SIZE-1:0] d);
    i_l_valid = v; i_l_addr = a; i_l_data = d;
  endtask

  task automatic check_wb(input string tag, input logic we, input logic [AW-1:0] a,
                          input logic [DATA_SIZE-1:0] d);
    check({tag, ".wb"}, o_wb, we);
    if (we) begin
      check({tag, ".addr"}, o_wb_addr, a);
      check({tag, ".data"}, o_wb_data, d);
    end
  endtask

  initial begin
    i_reset = 1'b1;
    set_p(1'b0, '0, '0);
    set_l(1'b0, '0, '0);

    // Reset state
    step();
    step();
    check("rst.ready_low", o_l_ready, 1'b0);
    i_reset = 1'b0;
    #1;
    check("rst.ready", o_l_ready, 1'b1);
    check("rst.wb", o_wb, 1'b0);
    check("rst.wb_addr", o_wb_addr, 0);
    check("rst.wb_data", o_wb_data, 0);
    check("rst.stall", o_p_stall, 1'b0);
    check("rst.count", o_l_count, 0);

    // Single P write
    set_p(1'b1, 5'd5, 32'hDEADBEEF);
    step();
    set_p(1'b0, '0, '0);
    check_wb("p5", 1'b1, 5'd5, 32'hDEADBEEF);
    step();
    check("p5.idle", o_wb, 1'b0);

    // Back-to-back L pushes with P idle
    set_l(1'b1, 5'd7, 32'h11);
    step();
    check("l2.count0", o_l_count, 1);
    check("l2.nowb", o_wb, 1'b0);
    set_l(1'b1, 5'd8, 32'h22);
    step();
    set_l(1'b0, '0, '0);
    check("l2.count1", o_l_count, 1);
    check_wb("l2.w7", 1'b1, 5'd7, 32'h11);
    step();
    check("l2.count2", o_l_count, 0);
    check_wb("l2.w8", 1'b1, 5'd8, 32'h22);
    step();
    check("l2.idle", o_wb, 1'b0);

    // Starvation: P valid every cycle, one L result
    set_p(1'b1, 5'd1, 32'hA0);
    set_l(1'b1, 5'd9, 32'h33);
    step();
    set_l(1'b0, '0, '0);
    check_wb("st.p0", 1'b1, 5'd1, 32'hA0);
    check("st.stall0", o_p_stall, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      set_p(1'b1, 5'd1, 32'hA0 + k);
      step();
      check_wb("st.pk", 1'b1, 5'd1, 32'hA0 + k);
      check("st.stallk", o_p_stall, k == 4);
    end
    set_p(1'b1, 5'd1, 32'hA5);  // presented in the stall cycle, held one more cycle
    step();
    check_wb("st.l9", 1'b1, 5'd9, 32'h33);
    check("st.stall_off", o_p_stall, 1'b0);
    check("st.count", o_l_count, 0);
    step();
    check_wb("st.p5", 1'b1, 5'd1, 32'hA5);
    set_p(1'b0, '0, '0);
    step();
    check("st.idle", o_wb, 1'b0);

    // WAW kill: L and P to register 3 in the same cycle
    set_p(1'b1, 5'd3, 32'hBB);
    set_l(1'b1, 5'd3, 32'hAA);
    step();
    set_p(1'b0, '0, '0);
    set_l(1'b0, '0, '0);
    check_wb("waw.p", 1'b1, 5'd3, 32'hBB);
    check("waw.count1", o_l_count, 1);
    step();
    check("waw.nowb", o_wb, 1'b0);
    check("waw.count0", o_l_count, 0);
    step();
    check("waw.idle", o_wb, 1'b0);

    // Full FIFO under continuous P, third result held by the source
    set_p(1'b1, 5'd2, 32'hC0);
    set_l(1'b1, 5'd10, 32'h44);
    step();
    check("full.count1", o_l_count, 1);
    check("full.ready1", o_l_ready, 1'b1);
    set_l(1'b1, 5'd11, 32'h55);
    step();
    check("full.count2", o_l_count, 2);
    check("full.ready0", o_l_ready, 1'b0);
    set_l(1'b1, 5'd12, 32'h66);
    for (int k = 2; k <= 4; k++) begin
      step();
      check("full.hold_ready", o_l_ready, 1'b0);
      check("full.stallk", o_p_stall, k == 4);
    end
    step();
    check_wb("full.l10", 1'b1, 5'd10, 32'h44);
    check("full.ready_back", o_l_ready, 1'b1);
    check("full.count_pop", o_l_count, 1);
    check("full.stall_off", o_p_stall, 1'b0);
    step();
    set_l(1'b0, '0, '0);
    set_p(1'b0, '0, '0);
    check("full.count_push", o_l_count, 2);
    check_wb("full.p", 1'b1, 5'd2, 32'hC0);
    step();
    check_wb("full.l11", 1'b1, 5'd11, 32'h55);
    check("full.count_a", o_l_count, 1);
    step();
    check_wb("full.l12", 1'b1, 5'd12, 32'h66);
    check("full.count_b", o_l_count, 0);
    step();
    check("full.once", o_wb, 1'b0);
    check("full.count_c", o_l_count, 0);

    // Write to x0, then reset right after an L push
    set_p(1'b1, 5'd0, 32'h5);
    step();
    set_p(1'b0, '0, '0);
    check("x0.nowb", o_wb, 1'b0);
    set_l(1'b1, 5'd13, 32'h77);
    step();
    set_l(1'b0, '0, '0);
    check("mid.count1", o_l_count, 1);
    i_reset = 1'b1;
    step();
    check("mid.wb", o_wb, 1'b0);
    check("mid.count", o_l_count, 0);
    check("mid.ready_low", o_l_ready, 1'b0);
    i_reset = 1'b0;
    #1;
    check("mid.ready", o_l_ready, 1'b1);
    step();
    check("mid.nowb1", o_wb, 1'b0);
    check("mid.count_after", o_l_count, 0);
    step();
    check("mid.nowb2", o_wb, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Arbiter for the single register-file write port in the decode stage. Shares the port between the in-order pipeline write-back stream (P) and a long-latency result stream (L: loads, multi-cycle units), which is buffered in a small FIFO. P has priority, and a starvation guard stalls the pipeline so that L results drain. A younger P write kills older queued L writes to the same register (WAW).

## Interface
Parameters:
- DATA_SIZE, 32, register width
- NUM_REGS, 32, register count; address width AW = $clog2(NUM_REGS)
- FIFO_DEPTH, 2, L buffer entries (>=2)
- MAX_WAIT, 4, cycles a live L head may go ungranted before the pipeline is stalled (>=1)

Ports:
- i_aclk  in  1  system clock. One clock domain only.
- i_reset  in  1  reset, synchronous, active-high
- i_p_valid  in  1  pipeline write-back request
- i_p_addr  in  AW  pipeline destination register
- i_p_data  in  DATA_SIZE  pipeline write data
- o_p_stall  out  1  port taken by L this cycle; pipeline must hold P request and freeze
- i_l_valid  in  1  L result valid
- o_l_ready  out  1  FIFO can accept an L result
- i_l_addr  in  AW  L destination register
- i_l_data  in  DATA_SIZE  L write data
- o_wb  out  1  register-file write enable
- o_wb_addr  out  AW  register-file write address
- o_wb_data  out  DATA_SIZE  register-file write data
- o_l_count  out  $clog2(FIFO_DEPTH+1)  occupied FIFO entries, including killed entries

## Operation
- FIFO: circular buffer with head/tail pointers, count, and a per-slot kill bit. Pointers wrap modulo FIFO_DEPTH.
- Push: i_l_valid && o_l_ready. o_l_ready = (count < FIFO_DEPTH). Ready does not depend on a same-cycle pop, so a full FIFO with a pop still reports ready=0.
- Live head: count != 0 and head kill bit clear.
- Starve flag: wait_cnt == MAX_WAIT && live head.
- o_p_stall = starve flag. It is decoded from registers only, with no input-to-output combinational path.
- Grant selection each cycle:
  - If the starve flag is set, grant the L head.
  - Else if i_p_valid is high, grant P.
  - Else if there is a live head, grant the L head.
  - Else there is no grant.
- Killed head: popped in any cycle without using the port. This pop may coincide with a P grant. A live L grant also pops the head.
- WAW kill: when P is granted with i_p_addr = A != 0, every FIFO entry with address A sets its kill bit. This includes an entry pushed in the same cycle, and it is evaluated before the head-grant decision of the next cycle.
- wait_cnt:
  - Increments (saturating at MAX_WAIT) in each cycle with a live head that is not granted.
  - Clears when the head is granted or popped, or when no live head exists.
- Write: the granted request is registered into o_wb_addr/o_wb_data.
  - o_wb = 1 only if a grant occurred and the address != 0.
  - A write to x0 consumes the grant but produces o_wb = 0.
- Push and pop in the same cycle: count is unchanged and both pointers advance.

## Timing
- Reset (i_reset high at a rising edge):
  - count, wait_cnt, head/tail pointers and kill bits are cleared.
  - o_wb=0, o_wb_addr=0, o_wb_data=0, o_p_stall=0, o_l_count=0.
  - o_l_ready is forced to 0 while i_reset is high and becomes 1 in the first cycle after reset.
- Reset asserted mid-operation discards all queued L entries and any write registered in that cycle.
- Grant to o_wb latency: 1 cycle.
- L push at edge N:
  - The entry is the head in cycle N+1.
  - If the head is granted in N+1, o_wb is seen in N+2. This is the minimum L latency of 2 cycles.
- Starvation, with P valid every cycle: the L head is pushed, then MAX_WAIT ungranted cycles pass, then o_p_stall=1 for exactly one cycle while the head is granted.
- The P request must remain stable during the o_p_stall cycle. P is granted in the following cycle.
- Worst-case live-head wait: MAX_WAIT+1 cycles from becoming the head to grant.
- Full FIFO: o_l_ready=0. The L source holds i_l_valid/addr/data until ready is high.

## Test plan
- Reset, then P writes (addr 5, 0xDEADBEEF) -> o_wb=1, o_wb_addr=5, o_wb_data=0xDEADBEEF one cycle later. Directly after reset, o_l_ready=1 and all other outputs are 0.
- Idle P, L pushes (7, 0x11) then (8, 0x22) on back-to-back cycles -> writes to 7 and 8 appear in cycles N+2 and N+3. o_l_count sequence is 1, 1, 0.
- P valid every cycle (addr 1), L pushes (9, 0x33) -> o_p_stall=1 in exactly one cycle, MAX_WAIT=4 cycles after the push becomes the head. Register 9 is written in the next cycle, and no P write is lost (same P request re-presented after the stall).
- L pushes (3, 0xAA), and P writes (3, 0xBB) in the same cycle -> only 0xBB is written to register 3. The killed entry pops with no o_wb, and o_l_count returns to 0.
- Fill the FIFO (2 entries) while P is continuously valid -> o_l_ready=0 and a third L result is held. Once a starve grant pops an entry, ready returns to 1 and the held result is accepted exactly once.
- P write to x0 with data 0x5, and assert i_reset in the cycle after an L push -> o_wb stays 0, and after reset o_l_count=0 with no L write emitted.
